// File: rtl/rmt_phv_pkg.sv
// Shared PHV layout constants and value-type encodings
// for the sub-parser / PHV collector datapath.
package rmt_phv_pkg;

  localparam int PHV_LEN   = 1024;
  localparam int VAL_LEN   = 48;
  localparam int META_LEN  = 256;
  localparam int ACC_LEN   = 768;

  localparam int BASE_6B   = 0;
  localparam int BASE_4B   = 384;
  localparam int BASE_2B   = 640;
  localparam int BASE_META = 768;

  localparam int N_6B = 8;
  localparam int N_4B = 8;
  localparam int N_2B = 8;

  typedef enum logic [1:0] {
    TYPE_NONE = 2'b00,
    TYPE_2B   = 2'b01,
    TYPE_4B   = 2'b10,
    TYPE_6B   = 2'b11
  } val_type_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/phv_buf2.sv
// Two-entry valid/ready PHV FIFO; head entry drives the output
// directly so data and valid hold while the consumer stalls.
module phv_buf2
  import rmt_phv_pkg::*;
#(
  parameter int W = PHV_LEN
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         full,
  output logic [1:0]   count
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         valid_q, valid_d;
  logic         full_q, full_d;
  logic         pop;

  always_comb begin
    pop     = valid_q & out_ready;
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = BUF_FULL;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = push_data;
          else      state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    valid_d = (state_d != BUF_EMPTY);
    full_d  = (state_d == BUF_FULL);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign full      = full_q;
  assign count     = state_q;

endmodule

// File: rtl/phv_collector.sv
// Accumulates typed field values into a PHV and buffers closed packets.
// Define PHV_COLLECT_STATS_EN to build the pkt_cnt / drop_cnt counters.
module phv_collector
  import rmt_phv_pkg::*;
#(
  parameter int VAL_LEN  = 48,
  parameter int META_LEN = 256,
  parameter int PHV_LEN  = 1024
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                val_in_valid,
  input  logic [VAL_LEN-1:0]  val_in,
  input  logic [1:0]          val_in_type,
  input  logic [2:0]          val_in_seq,
  input  logic                val_in_last,
  input  logic [META_LEN-1:0] meta_in,
  output logic                collector_ready,
  output logic                phv_out_valid,
  output logic [PHV_LEN-1:0]  phv_out,
  input  logic                phv_out_ready,
  output logic [31:0]         pkt_cnt,
  output logic [31:0]         drop_cnt
);

  logic [ACC_LEN-1:0] acc_q, acc_d, acc_w;
  logic               close, room, push, buf_full;
  logic [1:0]         buf_count;
  logic [9:0]         seq_x;

  // acc_w is the container region with this cycle's write merged in
  always_comb begin
    acc_w = acc_q;
    seq_x = {7'd0, val_in_seq};
    if (val_in_valid) begin
      unique case (val_type_e'(val_in_type))
        TYPE_NONE: ;
        TYPE_2B:   acc_w[BASE_2B + 16*seq_x +: 16] = val_in[15:0];
        TYPE_4B:   acc_w[BASE_4B + 32*seq_x +: 32] = val_in[31:0];
        TYPE_6B:   acc_w[BASE_6B + 48*seq_x +: 48] = val_in[47:0];
      endcase
    end
    close = val_in_valid & val_in_last;
    room  = (buf_count != 2'd2) | (phv_out_valid & phv_out_ready);
    push  = close & room;
    acc_d = close ? '0 : acc_w;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  phv_buf2 #(.W(PHV_LEN)) u_buf (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data ({meta_in, acc_w}),
    .out_ready (phv_out_ready),
    .out_valid (phv_out_valid),
    .out_data  (phv_out),
    .full      (buf_full),
    .count     (buf_count)
  );

  assign collector_ready = ~buf_full;

`ifdef PHV_COLLECT_STATS_EN
  logic [31:0] pkt_q, pkt_d, drop_q, drop_d;

  always_comb begin
    pkt_d  = pkt_q + {31'd0, push};
    drop_d = drop_q;
    if (close && !room && drop_q != 32'hFFFF_FFFF)
      drop_d = drop_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      drop_q <= drop_d;
    end
  end

  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drop_q;
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_phv_collector.sv
// Randomized + directed bench for phv_collector against a
// container-array / queue reference model.
module tb_phv_collector;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          vv;
  logic [47:0]   vd;
  logic [1:0]    vt;
  logic [2:0]    vs;
  logic          vl;
  logic [255:0]  meta;
  logic          rdy;
  logic          c_rdy;
  logic          o_valid;
  logic [1023:0] o_phv;
  logic [31:0]   pkt_cnt, drop_cnt;

  int n_vec = 0;
  int n_bad = 0;

  logic [47:0]   m6[8];
  logic [31:0]   m4[8];
  logic [15:0]   m2[8];
  logic [1023:0] q[$];
  int unsigned   mpkt, mdrop;

  localparam logic [255:0] META5A = {32{8'h5A}};

  always #5 clk = ~clk;

  phv_collector dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .val_in_valid    (vv),
    .val_in          (vd),
    .val_in_type     (vt),
    .val_in_seq      (vs),
    .val_in_last     (vl),
    .meta_in         (meta),
    .collector_ready (c_rdy),
    .phv_out_valid   (o_valid),
    .phv_out         (o_phv),
    .phv_out_ready   (rdy),
    .pkt_cnt         (pkt_cnt),
    .drop_cnt        (drop_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", nm, a, e);
    end
  endtask

  task automatic chk_phv(input string nm, input logic [1023:0] a, input logic [1023:0] e);
    n_vec++;
    if (a !== e) begin
      int w;
      w = 0;
      for (int i = 31; i >= 0; i--)
        if (a[32*i +: 32] !== e[32*i +: 32]) w = i;
      n_bad++;
      $display("FAIL %s word %0d got %h exp %h", nm, w, a[32*w +: 32], e[32*w +: 32]);
    end
  endtask

  function automatic logic [1023:0] build(input logic [255:0] m);
    logic [1023:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p[48*i +: 48]       = m6[i];
      p[384 + 32*i +: 32] = m4[i];
      p[640 + 16*i +: 16] = m2[i];
    end
    p[1023:768] = m;
    return p;
  endfunction

  task automatic clear_acc();
    for (int i = 0; i < 8; i++) begin
      m6[i] = '0;
      m4[i] = '0;
      m2[i] = '0;
    end
  endtask

  task automatic model_edge();
    bit pop, room;
    pop = (q.size() > 0) && rdy;
    if (!aresetn) begin
      clear_acc();
      q.delete();
      mpkt  = 0;
      mdrop = 0;
      return;
    end
    if (vv) begin
      case (vt)
        2'b01: m2[vs] = vd[15:0];
        2'b10: m4[vs] = vd[31:0];
        2'b11: m6[vs] = vd;
        default: ;
      endcase
    end
    room = (q.size() < 2) || pop;
    if (pop) void'(q.pop_front());
    if (vv && vl) begin
      if (room) begin
        q.push_back(build(meta));
        mpkt++;
      end else if (mdrop != 32'hFFFF_FFFF) begin
        mdrop++;
      end
      clear_acc();
    end
  endtask

  task automatic check();
    chk("valid", {31'd0, o_valid}, {31'd0, q.size() > 0});
    chk("ready", {31'd0, c_rdy}, {31'd0, q.size() < 2});
    if (o_valid && q.size() > 0) chk_phv("phv", o_phv, q[0]);
`ifdef PHV_COLLECT_STATS_EN
    chk("pkt_cnt", pkt_cnt, mpkt);
    chk("drop_cnt", drop_cnt, mdrop);
`else
    chk("pkt_cnt", pkt_cnt, 32'd0);
    chk("drop_cnt", drop_cnt, 32'd0);
`endif
  endtask

  task automatic step(input bit v, input logic [1:0] t, input logic [2:0] s,
                      input logic [47:0] d, input bit l, input logic [255:0] m,
                      input bit r);
    vv = v; vt = t; vs = s; vd = d; vl = l; meta = m; rdy = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check();
  endtask

  task automatic idle(input bit r);
    step(1'b0, 2'b00, 3'd0, 48'd0, 1'b0, '0, r);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    idle(1'b0);
    chk_phv("rst_phv", o_phv, '0);
    aresetn = 1'b1;
  endtask

  logic [1023:0] mask;

  initial begin
    aresetn = 1'b0;
    vv = 0; vt = 0; vs = 0; vd = 0; vl = 0; meta = 0; rdy = 0;
    clear_acc();
    mpkt = 0; mdrop = 0;
    do_reset();
    chk("rst_ready", {31'd0, c_rdy}, 32'd1);

    // single packet, three container types
    step(1, 2'b11, 3'd2, 48'hAABBCCDDEEFF, 0, META5A, 1);
    step(1, 2'b10, 3'd7, 48'h12345678, 0, META5A, 1);
    step(1, 2'b01, 3'd0, 48'hBEEF, 1, META5A, 1);
    chk("t1_valid", {31'd0, o_valid}, 32'd1);
    chk("t1_6b", o_phv[127:96], 32'hCCDDEEFF);
    chk("t1_6b_hi", {16'd0, o_phv[143:128]}, 32'h0000AABB);
    chk("t1_4b", o_phv[639:608], 32'h12345678);
    chk("t1_2b", {16'd0, o_phv[655:640]}, 32'h0000BEEF);
    chk_phv("t1_meta", {768'd0, o_phv[1023:768]}, {768'd0, META5A});
    mask = '0;
    mask[143:96] = '1; mask[639:608] = '1; mask[655:640] = '1; mask[1023:768] = '1;
    chk_phv("t1_rest0", o_phv & ~mask, '0);
`ifdef PHV_COLLECT_STATS_EN
    chk("t1_pkt", pkt_cnt, 32'd1);
`endif

    // last write wins, type-00 close writes nothing
    step(1, 2'b01, 3'd3, 48'h1111, 0, '0, 1);
    step(1, 2'b01, 3'd3, 48'h2222, 0, '0, 1);
    step(1, 2'b00, 3'd5, 48'hFFFFFFFFFFFF, 1, '0, 1);
    chk_phv("t2_acc", {256'd0, o_phv[767:0]}, {1008'd0, 16'h2222} << 688);

    // overflow with ready low
    idle(1);
    step(1, 2'b10, 3'd1, 48'hA1, 1, 256'h1, 0);
    step(1, 2'b10, 3'd2, 48'hA2, 1, 256'h2, 0);
    chk("t3_rdy_low", {31'd0, c_rdy}, 32'd0);
    step(1, 2'b10, 3'd3, 48'hA3, 1, 256'h3, 0);
`ifdef PHV_COLLECT_STATS_EN
    chk("t3_drop", drop_cnt, 32'd1);
`endif
    chk("t3_head", o_phv[415:384], 32'h0000_0000);
    chk("t3_head4b", o_phv[447:416], 32'h0000_00A1);
    idle(1);
    chk("t3_second", o_phv[479:448], 32'h0000_00A2);
    idle(1);
    chk("t3_rdy_back", {31'd0, c_rdy}, 32'd1);

    // full + pop + push in one cycle
    step(1, 2'b11, 3'd0, 48'hB1, 1, 256'h11, 0);
    step(1, 2'b11, 3'd1, 48'hB2, 1, 256'h12, 0);
    step(1, 2'b11, 3'd2, 48'hB3, 1, 256'h13, 1);
    chk("t4_still_full", {31'd0, c_rdy}, 32'd0);
    chk("t4_head", o_phv[79:48], 32'h0000_00B2);
`ifdef PHV_COLLECT_STATS_EN
    chk("t4_nodrop", drop_cnt, 32'd1);
`endif
    idle(1); idle(1); idle(1);

    // reset mid-packet
    step(1, 2'b11, 3'd4, 48'hDEADBEEFCAFE, 0, '0, 1);
    step(1, 2'b01, 3'd6, 48'h7777, 0, '0, 1);
    do_reset();
    step(1, 2'b10, 3'd0, 48'h55, 1, 256'h9, 1);
    chk_phv("t5_clean", o_phv, {256'h9, 768'd0} | ({992'd0, 32'h55} << 384));
`ifdef PHV_COLLECT_STATS_EN
    chk("t5_pkt", pkt_cnt, 32'd1);
`endif
    idle(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0,
             2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)),
             {16'($urandom), $urandom},
             $urandom_range(0, 3) == 0,
             {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 2) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
